// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the board fetch arbiter
package vga_pkg;

  localparam int         IDX_W       = 5;
  localparam logic [9:0] BOARD_BASE  = 10'h100;
  localparam int         BOARD_WORDS = 30;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  typedef enum logic {
    SRC_VGA,
    SRC_EXT
  } src_t;

  typedef struct packed {
    logic             valid;
    src_t             src;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/board_fetch_arbiter_if.sv
// rtl/board_fetch_arbiter_if.sv - BRAM port B, external requester and position file signals
interface board_fetch_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
);
  import vga_pkg::*;

  logic                  frame_start;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  ext_req;
  logic                  ext_we;
  logic [ADDR_WIDTH-1:0] ext_addr;
  logic [WIDTH-1:0]      ext_wdata;
  logic                  ext_gnt;
  logic                  ext_rvalid;
  logic [WIDTH-1:0]      ext_rdata;
  logic                  pos_wr_en;
  logic [IDX_W-1:0]      pos_wr_idx;
  logic [WIDTH-1:0]      pos_wr_data;
  logic                  fetch_busy;
  logic                  frame_done;
  logic                  overrun;

  modport master (
    input  frame_start, mem_rdata, ext_req, ext_we, ext_addr, ext_wdata,
    output mem_addr, mem_we, mem_wdata, ext_gnt, ext_rvalid, ext_rdata,
           pos_wr_en, pos_wr_idx, pos_wr_data, fetch_busy, frame_done, overrun
  );

  modport slave (
    output frame_start, mem_rdata, ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_addr, mem_we, mem_wdata, ext_gnt, ext_rvalid, ext_rdata,
           pos_wr_en, pos_wr_idx, pos_wr_data, fetch_busy, frame_done, overrun
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - read tag delay line matching the BRAM read latency
module rd_tag_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    clr,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [DEPTH];
  rd_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/board_fetch_arbiter.sv
// rtl/board_fetch_arbiter.sv - per-frame board word fetch sharing BRAM port B with an external master
module board_fetch_arbiter
  import vga_pkg::*;
#(
  parameter int                    WIDTH      = 16,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(BOARD_BASE),
  parameter int                    NUM_WORDS  = BOARD_WORDS,
  parameter int                    RD_LATENCY = 1,
  parameter int                    MAX_STALL  = 8
) (
  input logic                   clk50MHz,
  input logic                   clr,
  board_fetch_arbiter_if.master bus
);

  if (NUM_WORDS < 1 || NUM_WORDS > 32) begin : g_bad_num_words
    $error("NUM_WORDS must lie in 1..32");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_rd_latency
    $error("RD_LATENCY must lie in 1..2");
  end

  localparam int                 STALL_W     = $clog2(MAX_STALL + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_WORDS - 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  overrun_q, overrun_d;
  logic                  busy, ext_gnt, issue_vga;
  logic                  vga_ret, ext_ret, frame_done_w;
  rd_tag_t               push_tag, exit_tag;

  assign vga_ret      = exit_tag.valid && (exit_tag.src == SRC_VGA);
  assign ext_ret      = exit_tag.valid && (exit_tag.src == SRC_EXT);
  assign frame_done_w = vga_ret && (exit_tag.idx == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stall_d   = '0;
    addr_d    = addr_q;
    push_tag  = '0;
    busy      = (state_q != IDLE);
    overrun_d = overrun_q | (busy & bus.frame_start);
    // VGA owns the port during FETCH except for the forced slot after MAX_STALL denials
    ext_gnt   = bus.ext_req && ((state_q != FETCH) || (stall_q == STALL_LIMIT));
    issue_vga = (state_q == FETCH) && !ext_gnt;

    if (ext_gnt) begin
      addr_d         = bus.ext_addr;
      push_tag.valid = !bus.ext_we;
      push_tag.src   = SRC_EXT;
    end else if (issue_vga) begin
      addr_d         = BASE_ADDR + ADDR_WIDTH'(idx_q);
      push_tag.valid = 1'b1;
      push_tag.src   = SRC_VGA;
      push_tag.idx   = idx_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.ext_req && !ext_gnt) begin
          stall_d = stall_q + STALL_W'(1);
        end
        if (issue_vga) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (frame_done_w) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50MHz) begin
    if (clr) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      stall_q   <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      stall_q   <= stall_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
    end
  end

  rd_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_tag_pipe (
    .clk     (clk50MHz),
    .clr     (clr),
    .tag_in  (push_tag),
    .tag_out (exit_tag)
  );

  assign bus.mem_addr    = addr_d;
  assign bus.mem_we      = ext_gnt && bus.ext_we;
  assign bus.mem_wdata   = ext_gnt ? bus.ext_wdata : {WIDTH{1'b0}};
  assign bus.ext_gnt     = ext_gnt;
  assign bus.ext_rvalid  = ext_ret;
  assign bus.ext_rdata   = ext_ret ? bus.mem_rdata : {WIDTH{1'b0}};
  assign bus.pos_wr_en   = vga_ret;
  assign bus.pos_wr_idx  = vga_ret ? exit_tag.idx : '0;
  assign bus.pos_wr_data = vga_ret ? bus.mem_rdata : {WIDTH{1'b0}};
  assign bus.fetch_busy  = busy;
  assign bus.frame_done  = frame_done_w;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_board_fetch_arbiter.sv
// tb/tb_board_fetch_arbiter.sv - scoreboard bench for board_fetch_arbiter
module tb_board_fetch_arbiter;

  typedef struct packed {
    logic [31:0] cyc;
    logic        en;
    logic [4:0]  idx;
    logic [15:0] data;
    logic        done;
  } pos_ev_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] data;
  } ext_ev_t;

  logic        clk = 1'b0;
  logic        clr;
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          c0 = 0;
  pos_ev_t     exp_pos[$];
  pos_ev_t     obs_pos[$];
  ext_ev_t     exp_ext[$];
  ext_ev_t     obs_ext[$];
  logic [15:0] wr_mem [0:1023];
  logic [1023:0] written;

  board_fetch_arbiter_if #(.WIDTH(16), .ADDR_WIDTH(10)) bus ();

  board_fetch_arbiter #(
    .WIDTH(16), .ADDR_WIDTH(10), .BASE_ADDR(10'h100),
    .NUM_WORDS(30), .RD_LATENCY(1), .MAX_STALL(8)
  ) dut (
    .clk50MHz (clk),
    .clr      (clr),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] gval(input logic [9:0] a);
    logic [15:0] w;
    w = {6'd0, a};
    return (a == 10'h005) ? 16'hBEEF : ((w * 16'h0123) ^ 16'h5A5A);
  endfunction

  // One-cycle-latency BRAM, read-first
  always @(posedge clk) begin
    if (bus.mem_we) begin
      wr_mem[bus.mem_addr]  <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= (written[bus.mem_addr] === 1'b1) ? wr_mem[bus.mem_addr] : gval(bus.mem_addr);
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    if (bus.pos_wr_en || bus.frame_done)
      obs_pos.push_back('{cyc: 32'(cyc), en: bus.pos_wr_en, idx: bus.pos_wr_idx,
                          data: bus.pos_wr_data, done: bus.frame_done});
    if (bus.ext_rvalid)
      obs_ext.push_back('{cyc: 32'(cyc), data: bus.ext_rdata});
  endtask

  task automatic clear_sb();
    exp_pos.delete();
    obs_pos.delete();
    exp_ext.delete();
    obs_ext.delete();
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    c0 = cyc;
  endtask

  // Expected board words: idx i issues on cycle i+1, one cycle later from the ext slot on
  task automatic push_frame(input int last, input int pk);
    for (int i = 0; i <= last; i++) begin
      int k;
      k = (pk == 0 || i + 1 < pk) ? i + 1 : i + 2;
      exp_pos.push_back('{cyc: 32'(c0 + k + 1), en: 1'b1, idx: 5'(i),
                          data: gval(10'h100 + 10'(i)), done: (i == 29)});
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    bus.frame_start = 1'b0;
    bus.ext_req = 1'b0;
    bus.ext_we = 1'b0;
    bus.ext_addr = '0;
    bus.ext_wdata = '0;
    advance();
    advance();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.ext_gnt, bus.ext_rvalid, bus.ext_rdata,
         bus.pos_wr_en, bus.pos_wr_idx, bus.pos_wr_data, bus.fetch_busy, bus.frame_done,
         bus.overrun} !== 70'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got addr=%h we=%b busy=%b ovr=%b pos_en=%b want all zero",
               bus.mem_addr, bus.mem_we, bus.fetch_busy, bus.overrun, bus.pos_wr_en);
    end
    advance();
  endtask

  task automatic test_frame_fetch();
    clear_sb();
    start_frame();
    push_frame(29, 0);
    for (int k = 0; k <= 33; k++) begin
      sample();
      if (k >= 1 && k <= 30) begin
        tests_run++;
        if (bus.mem_addr !== 10'h100 + 10'(k - 1)) begin
          tests_failed++;
          $display("FAIL fetch_addr k=%0d got=%h want=%h", k, bus.mem_addr, 10'h100 + 10'(k - 1));
        end
      end
      if (k == 31 || k == 32) begin
        tests_run++;
        if (bus.fetch_busy !== (k == 31)) begin
          tests_failed++;
          $display("FAIL fetch_busy k=%0d got=%b want=%b", k, bus.fetch_busy, (k == 31));
        end
      end
      advance();
      bus.frame_start = 1'b0;
    end
    tests_run++;
    if (obs_pos.size() != exp_pos.size()) begin
      tests_failed++;
      $display("FAIL fetch_count got=%0d want=%0d", obs_pos.size(), exp_pos.size());
    end
    for (int i = 0; i < exp_pos.size() && i < obs_pos.size(); i++) begin
      tests_run++;
      if (obs_pos[i] !== exp_pos[i]) begin
        tests_failed++;
        $display("FAIL fetch_word[%0d] got=%h want=%h", i, obs_pos[i], exp_pos[i]);
      end
    end
    tests_run++;
    if (bus.mem_addr !== 10'h11D) begin
      tests_failed++;
      $display("FAIL idle_addr_hold got=%h want=11d", bus.mem_addr);
    end
  endtask

  task automatic test_ext_idle_read();
    clear_sb();
    bus.ext_req = 1'b1;
    bus.ext_we = 1'b0;
    bus.ext_addr = 10'h005;
    exp_ext.push_back('{cyc: 32'(cyc + 1), data: 16'hBEEF});
    sample();
    tests_run++;
    if (bus.ext_gnt !== 1'b1 || bus.mem_addr !== 10'h005 || bus.mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_grant got gnt=%b addr=%h we=%b want gnt=1 addr=005 we=0",
               bus.ext_gnt, bus.mem_addr, bus.mem_we);
    end
    advance();
    bus.ext_req = 1'b0;
    sample();
    advance();
    tests_run++;
    if (obs_ext.size() != exp_ext.size()) begin
      tests_failed++;
      $display("FAIL idle_read_count got=%0d want=%0d", obs_ext.size(), exp_ext.size());
    end
    for (int i = 0; i < exp_ext.size() && i < obs_ext.size(); i++) begin
      tests_run++;
      if (obs_ext[i] !== exp_ext[i]) begin
        tests_failed++;
        $display("FAIL idle_read[%0d] got=%h want=%h", i, obs_ext[i], exp_ext[i]);
      end
    end
  endtask

  task automatic test_ext_starve();
    clear_sb();
    start_frame();
    push_frame(29, 11);
    for (int k = 0; k <= 34; k++) begin
      if (k == 3) begin
        bus.ext_req = 1'b1;
        bus.ext_we = 1'b1;
        bus.ext_addr = 10'h040;
        bus.ext_wdata = 16'h1234;
      end
      sample();
      if (k >= 3 && k <= 11) begin
        tests_run++;
        if (bus.ext_gnt !== (k == 11)) begin
          tests_failed++;
          $display("FAIL starve_gnt k=%0d got=%b want=%b", k, bus.ext_gnt, (k == 11));
        end
      end
      if (k == 11) begin
        tests_run++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'h040 || bus.mem_wdata !== 16'h1234) begin
          tests_failed++;
          $display("FAIL starve_write got we=%b addr=%h data=%h want we=1 addr=040 data=1234",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (k == 32 || k == 33) begin
        tests_run++;
        if (bus.fetch_busy !== (k == 32)) begin
          tests_failed++;
          $display("FAIL starve_busy k=%0d got=%b want=%b", k, bus.fetch_busy, (k == 32));
        end
      end
      advance();
      bus.frame_start = 1'b0;
      if (k == 11) begin
        bus.ext_req = 1'b0;
        bus.ext_we = 1'b0;
      end
    end
    tests_run++;
    if (obs_pos.size() != exp_pos.size() || obs_ext.size() != 0) begin
      tests_failed++;
      $display("FAIL starve_count got pos=%0d ext=%0d want pos=%0d ext=0",
               obs_pos.size(), obs_ext.size(), exp_pos.size());
    end
    for (int i = 0; i < exp_pos.size() && i < obs_pos.size(); i++) begin
      tests_run++;
      if (obs_pos[i] !== exp_pos[i]) begin
        tests_failed++;
        $display("FAIL starve_word[%0d] got=%h want=%h", i, obs_pos[i], exp_pos[i]);
      end
    end
    tests_run++;
    if (wr_mem[10'h040] !== 16'h1234) begin
      tests_failed++;
      $display("FAIL starve_mem got=%h want=1234", wr_mem[10'h040]);
    end
  endtask

  task automatic test_overrun();
    clear_sb();
    start_frame();
    push_frame(29, 0);
    for (int k = 0; k <= 33; k++) begin
      if (k == 5) bus.frame_start = 1'b1;
      sample();
      if (k >= 1 && k <= 30) begin
        tests_run++;
        if (bus.mem_addr !== 10'h100 + 10'(k - 1)) begin
          tests_failed++;
          $display("FAIL overrun_addr k=%0d got=%h want=%h", k, bus.mem_addr, 10'h100 + 10'(k - 1));
        end
      end
      if (k == 5 || k == 6 || k == 33) begin
        tests_run++;
        if (bus.overrun !== (k != 5)) begin
          tests_failed++;
          $display("FAIL overrun_flag k=%0d got=%b want=%b", k, bus.overrun, (k != 5));
        end
      end
      advance();
      bus.frame_start = 1'b0;
    end
    tests_run++;
    if (obs_pos.size() != exp_pos.size()) begin
      tests_failed++;
      $display("FAIL overrun_count got=%0d want=%0d", obs_pos.size(), exp_pos.size());
    end
    for (int i = 0; i < exp_pos.size() && i < obs_pos.size(); i++) begin
      tests_run++;
      if (obs_pos[i] !== exp_pos[i]) begin
        tests_failed++;
        $display("FAIL overrun_word[%0d] got=%h want=%h", i, obs_pos[i], exp_pos[i]);
      end
    end
  endtask

  task automatic test_clr_mid_fetch();
    do_reset();
    clear_sb();
    start_frame();
    push_frame(9, 0);
    for (int k = 0; k <= 15; k++) begin
      if (k == 11) clr = 1'b1;
      sample();
      if (k == 12) begin
        tests_run++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.ext_gnt, bus.ext_rvalid, bus.ext_rdata,
             bus.pos_wr_en, bus.pos_wr_idx, bus.pos_wr_data, bus.fetch_busy, bus.frame_done,
             bus.overrun} !== 70'd0) begin
          tests_failed++;
          $display("FAIL clr_outputs got addr=%h busy=%b ovr=%b pos_en=%b want all zero",
                   bus.mem_addr, bus.fetch_busy, bus.overrun, bus.pos_wr_en);
        end
      end
      advance();
      bus.frame_start = 1'b0;
      clr = 1'b0;
    end
    tests_run++;
    if (obs_pos.size() != exp_pos.size()) begin
      tests_failed++;
      $display("FAIL clr_count got=%0d want=%0d", obs_pos.size(), exp_pos.size());
    end
    for (int i = 0; i < exp_pos.size() && i < obs_pos.size(); i++) begin
      tests_run++;
      if (obs_pos[i] !== exp_pos[i]) begin
        tests_failed++;
        $display("FAIL clr_word[%0d] got=%h want=%h", i, obs_pos[i], exp_pos[i]);
      end
    end
    test_frame_fetch();
  endtask

  task automatic test_ext_last_fetch();
    clear_sb();
    start_frame();
    push_frame(29, 30);
    exp_ext.push_back('{cyc: 32'(c0 + 31), data: 16'hBEEF});
    for (int k = 0; k <= 34; k++) begin
      if (k == 22) begin
        bus.ext_req = 1'b1;
        bus.ext_we = 1'b0;
        bus.ext_addr = 10'h005;
      end
      sample();
      if (k == 29 || k == 30) begin
        tests_run++;
        if (bus.ext_gnt !== (k == 30)) begin
          tests_failed++;
          $display("FAIL last_gnt k=%0d got=%b want=%b", k, bus.ext_gnt, (k == 30));
        end
      end
      if (k == 31) begin
        tests_run++;
        if (bus.mem_addr !== 10'h11D) begin
          tests_failed++;
          $display("FAIL last_vga_addr got=%h want=11d", bus.mem_addr);
        end
      end
      advance();
      bus.frame_start = 1'b0;
      if (k == 30) bus.ext_req = 1'b0;
    end
    tests_run++;
    if (obs_pos.size() != exp_pos.size() || obs_ext.size() != exp_ext.size()) begin
      tests_failed++;
      $display("FAIL last_count got pos=%0d ext=%0d want pos=%0d ext=%0d",
               obs_pos.size(), obs_ext.size(), exp_pos.size(), exp_ext.size());
    end
    for (int i = 0; i < exp_pos.size() && i < obs_pos.size(); i++) begin
      tests_run++;
      if (obs_pos[i] !== exp_pos[i]) begin
        tests_failed++;
        $display("FAIL last_word[%0d] got=%h want=%h", i, obs_pos[i], exp_pos[i]);
      end
    end
    for (int i = 0; i < exp_ext.size() && i < obs_ext.size(); i++) begin
      tests_run++;
      if (obs_ext[i] !== exp_ext[i]) begin
        tests_failed++;
        $display("FAIL last_ext[%0d] got=%h want=%h", i, obs_ext[i], exp_ext[i]);
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.frame_start = 1'b0;
    bus.ext_req = 1'b0;
    bus.ext_we = 1'b0;
    bus.ext_addr = '0;
    bus.ext_wdata = '0;
    test_reset();
    test_frame_fetch();
    test_ext_idle_read();
    test_ext_starve();
    test_overrun();
    test_clr_mid_fetch();
    test_ext_last_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/board_fetch_arbiter.md
Name: board_fetch_arbiter

Overview:
- Owns BRAM port B, which is shared between the VGA board-state refresh and one external requester (I/O or debug master).
- On each frame_start pulse, fetches NUM_WORDS board words from BASE_ADDR upward and streams them to the VGA position register file. This replaces free-running address cycling inside the VGA controller.
- The external requester gets the port whenever the fetch is idle. During a fetch it gets the port through a starvation-bounded slot.

Parameters:
- WIDTH, 16: memory data width.
- ADDR_WIDTH, 10: memory address width.
- BASE_ADDR, 10'h100: first board word address.
- NUM_WORDS, 30: board words fetched per frame.
- RD_LATENCY, 1: BRAM read latency in cycles (range 1–2).
- MAX_STALL, 8: consecutive denied ext cycles before a forced grant.

Ports:
- clk50MHz  in  1  system clock.
- clr  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- mem_addr  out  ADDR_WIDTH  BRAM port B address.
- mem_we  out  1  BRAM port B write enable.
- mem_wdata  out  WIDTH  BRAM port B write data.
- mem_rdata  in  WIDTH  BRAM port B read data.
- ext_req  in  1  external access request; held with addr/we/wdata until granted.
- ext_we  in  1  external write (1) or read (0).
- ext_addr  in  ADDR_WIDTH  external address.
- ext_wdata  in  WIDTH  external write data.
- ext_gnt  out  1  access performed this cycle (combinational).
- ext_rvalid  out  1  external read data valid.
- ext_rdata  out  WIDTH  external read data.
- pos_wr_en  out  1  board word write strobe to the position register file.
- pos_wr_idx  out  5  board word index, 0..NUM_WORDS-1.
- pos_wr_data  out  WIDTH  board word.
- fetch_busy  out  1  high in FETCH or DRAIN.
- frame_done  out  1  one-cycle pulse with the last pos_wr_en.
- overrun  out  1  sticky flag: frame_start arrived while busy.

Behaviour:
- Reset (clr=1 at a clock edge):
  - State goes to IDLE; issue index, stall counter and tag pipeline are cleared.
  - Every output is 0 on the next cycle, including overrun and mem_addr.
  - In-flight reads never produce pos_wr_en or ext_rvalid.
- IDLE:
  - ext_gnt = ext_req.
  - frame_start moves the state to FETCH on the next cycle. A same-cycle ext_req is still granted in IDLE.
- FETCH:
  - Each cycle issues mem_addr = BASE_ADDR + idx, with mem_we = 0, then idx increments.
  - After issuing idx = NUM_WORDS-1, the state moves to DRAIN.
- Arbitration during FETCH:
  - VGA has priority. stall_cnt increments each cycle ext_req=1 and ext_gnt=0, and clears on a grant or when ext_req=0.
  - When stall_cnt == MAX_STALL, ext is granted that cycle. The VGA issue pauses for that cycle (idx held).
- DRAIN:
  - ext is granted freely, as in IDLE.
  - The state returns to IDLE the cycle after frame_done.
- Bus muxing:
  - When granted: mem_addr = ext_addr, mem_we = ext_we, mem_wdata = ext_wdata.
  - When nothing is issued: mem_addr holds its last value, mem_we = 0, mem_wdata = 0.
- Read return:
  - Each issued read pushes {valid, src, idx} into a RD_LATENCY-deep tag pipe.
  - At pipe exit with src = vga: pos_wr_en = 1, pos_wr_idx = idx, pos_wr_data = mem_rdata.
  - At pipe exit with src = ext: ext_rvalid = 1, ext_rdata = mem_rdata.
  - An ext write pushes no tag.
- frame_done is asserted with the pos_wr_en for idx NUM_WORDS-1.
- frame_start while fetch_busy: ignored, overrun is set to 1 and stays set until clr. The current fetch is unaffected.
- Width rules: BASE_ADDR + idx is computed in ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH. idx is 5 bits. NUM_WORDS ≤ 32 is checked by elaboration assertion.

Decomposition:
- Shared package (vga_pkg):
  - state enum {IDLE, FETCH, DRAIN}.
  - Source enum {SRC_VGA, SRC_EXT}.
  - Constants BOARD_BASE = 10'h100 and BOARD_WORDS = 30.
  - IDX_W = 5.
- One sub-module: rd_tag_pipe, a parameterized RD_LATENCY-deep shift register of {valid, src, idx} with synchronous clear.

Test Plan:
1. clr, then frame_start at cycle 0, no ext activity, RD_LATENCY = 1:
   - mem_addr = 0x100..0x11D on cycles 1–30.
   - pos_wr_en with idx 0..29 on cycles 2–31, data matching memory.
   - frame_done on cycle 31; fetch_busy low from cycle 32.
2. IDLE, ext read of 0x005 (memory holds 16'hBEEF):
   - ext_gnt in the same cycle.
   - ext_rvalid = 1 and ext_rdata = 16'hBEEF on the next cycle.
3. ext write to 0x040, held from FETCH cycle 3:
   - Denied for 8 cycles, granted on the 9th with mem_we = 1.
   - VGA indices stay contiguous, with no skip or duplicate.
   - frame_done arrives one cycle later than in scenario 1 (cycle 32).
4. Second frame_start at FETCH cycle 5:
   - overrun = 1 and stays set.
   - Address sequence and frame_done timing are unchanged from scenario 1.
5. clr asserted during FETCH at idx 10:
   - Next cycle all outputs are 0; no pos_wr_en follows.
   - A new frame_start restarts from idx 0 at 0x100.
6. ext read granted in the last FETCH cycle:
   - ext_rvalid and the final pos_wr_en return in their issue order, each one cycle after its issue.
